// File: rtl/onchip_mem_pkg.sv
// Shared constants and helpers for the dual-port on-chip memory.
package onchip_mem_pkg;

  localparam int DEF_DATA_W   = 32;
  localparam int DEF_ADDR_W   = 11;
  localparam int READ_LAT_MIN = 1;
  localparam int READ_LAT_MAX = 2;

  // byte lanes per word
  function automatic int be_w(input int data_w);
    return data_w / 8;
  endfunction

  // Map any requested latency onto the supported set {1, 2}.
  function automatic int legal_lat(input int lat);
    return (lat >= READ_LAT_MAX) ? READ_LAT_MAX : READ_LAT_MIN;
  endfunction

endpackage

// File: rtl/onchip_mem_bank.sv
// True-dual-port RAM: port A read-only, port B read/write with byte enables.
// Both read ports return the pre-write contents when a write hits the same
// word on the same edge. A write is visible to any read on the next edge.
module onchip_mem_bank
  import onchip_mem_pkg::*;
#(
  parameter int    DATA_W    = DEF_DATA_W,
  parameter int    ADDR_W    = DEF_ADDR_W,
  parameter string INIT_FILE = "",
  localparam int   BE_W      = be_w(DATA_W)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              a_rd,
  input  logic [ADDR_W-1:0] a_addr,
  output logic [DATA_W-1:0] a_q,
  input  logic              b_rd,
  input  logic              b_wr,
  input  logic [ADDR_W-1:0] b_addr,
  input  logic [BE_W-1:0]   b_be,
  input  logic [DATA_W-1:0] b_wdata,
  output logic [DATA_W-1:0] b_q
);

  localparam int    DEPTH            = 2 ** ADDR_W;
  // The init image is applied by the FPGA flow through ram_init_file;
  // nothing in the RTL consumes the name itself.
  localparam string unused_init_file = INIT_FILE;

  (* ram_init_file = INIT_FILE *)
  logic [BE_W-1:0][7:0] mem [DEPTH];

  // port B byte-lane writes; memory is never reset
  always_ff @(posedge clk) begin
    if (b_wr) begin
      for (int i = 0; i < BE_W; i++) begin
        if (b_be[i]) mem[b_addr][i] <= b_wdata[8*i +: 8];
      end
    end
  end

  // registered reads, loaded only by accepted reads so data holds otherwise
  always_ff @(posedge clk) begin
    if (reset) begin
      a_q <= '0;
      b_q <= '0;
    end else begin
      if (a_rd) a_q <= mem[a_addr];
      if (b_rd) b_q <= mem[b_addr];
    end
  end

endmodule

// File: rtl/onchip_mem_dp.sv
// Dual-port on-chip memory: port A instruction fetch, port B load/store.
// Pipelined Avalon-MM reads with latency 1 or 2, per-port readdatavalid,
// sticky cross-port collision flag.
module onchip_mem_dp
  import onchip_mem_pkg::*;
#(
  parameter int    DATA_W    = DEF_DATA_W,
  parameter int    ADDR_W    = DEF_ADDR_W,
  parameter int    READ_LAT  = 1,
  parameter string INIT_FILE = "../ROM.mif",
  localparam int   BE_W      = be_w(DATA_W)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clken,
  input  logic              a_chipselect,
  input  logic [ADDR_W-1:0] a_address,
  input  logic              a_read,
  output logic [DATA_W-1:0] a_readdata,
  output logic              a_readdatavalid,
  input  logic              b_chipselect,
  input  logic [ADDR_W-1:0] b_address,
  input  logic              b_read,
  input  logic              b_write,
  input  logic [BE_W-1:0]   b_byteenable,
  input  logic [DATA_W-1:0] b_writedata,
  output logic [DATA_W-1:0] b_readdata,
  output logic              b_readdatavalid,
  output logic              b_collision
);

  localparam int LAT = legal_lat(READ_LAT);

  logic              a_rd_acc, b_rd_acc, b_wr_acc;
  logic [DATA_W-1:0] a_q, b_q;
  logic [LAT:1]      a_vld_pipe, b_vld_pipe;

  // read+write on port B is a write only
  assign a_rd_acc = clken & a_chipselect & a_read;
  assign b_wr_acc = clken & b_chipselect & b_write;
  assign b_rd_acc = clken & b_chipselect & b_read & ~b_write;

  onchip_mem_bank #(
    .DATA_W    (DATA_W),
    .ADDR_W    (ADDR_W),
    .INIT_FILE (INIT_FILE)
  ) u_bank (
    .clk     (clk),
    .reset   (reset),
    .a_rd    (a_rd_acc),
    .a_addr  (a_address),
    .a_q     (a_q),
    .b_rd    (b_rd_acc),
    .b_wr    (b_wr_acc),
    .b_addr  (b_address),
    .b_be    (b_byteenable),
    .b_wdata (b_writedata),
    .b_q     (b_q)
  );

  // valid shift registers: advance on enabled edges, flushed by reset
  always_ff @(posedge clk) begin
    if (reset) begin
      a_vld_pipe <= '0;
      b_vld_pipe <= '0;
    end else if (clken) begin
      a_vld_pipe[1] <= a_rd_acc;
      b_vld_pipe[1] <= b_rd_acc;
      for (int s = 2; s <= LAT; s++) begin
        a_vld_pipe[s] <= a_vld_pipe[s-1];
        b_vld_pipe[s] <= b_vld_pipe[s-1];
      end
    end
  end

  assign a_readdatavalid = a_vld_pipe[LAT];
  assign b_readdatavalid = b_vld_pipe[LAT];

  generate
    if (LAT == 2) begin : g_oreg
      logic [DATA_W-1:0] a_oreg, b_oreg;
      // extra output stage, loaded only behind a valid first stage
      always_ff @(posedge clk) begin
        if (reset) begin
          a_oreg <= '0;
          b_oreg <= '0;
        end else if (clken) begin
          if (a_vld_pipe[1]) a_oreg <= a_q;
          if (b_vld_pipe[1]) b_oreg <= b_q;
        end
      end
      assign a_readdata = a_oreg;
      assign b_readdata = b_oreg;
    end else begin : g_noreg
      assign a_readdata = a_q;
      assign b_readdata = b_q;
    end
  endgenerate

  // sticky flag: port A read and port B write to one word on one edge
  always_ff @(posedge clk) begin
    if (reset) b_collision <= 1'b0;
    else if (a_rd_acc && b_wr_acc && (a_address == b_address)) b_collision <= 1'b1;
  end

endmodule

// File: doc/onchip_mem_dp.md
Name: onchip_mem_dp

Overview:
- Parametrised dual-port on-chip memory. Successor to the single-port 2K x 32 program RAM.
- Port A is the instruction-fetch slave; port B is the data load/store slave. Both are Avalon-MM slaves with pipelined reads.
- Adds:
  - configurable width, depth and read latency
  - per-port readdatavalid
  - same-port read-during-write forwarding
  - deterministic cross-port write collision resolution

Parameters:
DATA_W, 32, data width in bits; must be a multiple of 8
ADDR_W, 11, word-address width; depth = 2**ADDR_W
READ_LAT, 1, read latency in cycles; legal values 1 or 2 (2 = extra output register)
INIT_FILE, "../ROM.mif", memory initialisation file; "" = no initialisation
BE_W, DATA_W/8, byte-enable width (derived; not overridable)

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
clken  in  1  global clock enable; 0 freezes all state
a_chipselect  in  1  port A select
a_address  in  ADDR_W  port A word address
a_read  in  1  port A read request
a_readdata  out  DATA_W  port A read data
a_readdatavalid  out  1  port A read data valid
b_chipselect  in  1  port B select
b_address  in  ADDR_W  port B word address
b_read  in  1  port B read request
b_write  in  1  port B write request
b_byteenable  in  BE_W  port B byte lanes
b_writedata  in  DATA_W  port B write data
b_readdata  out  DATA_W  port B read data
b_readdatavalid  out  1  port B read data valid
b_collision  out  1  sticky flag: a port A read hit a port B write in the same cycle

Behaviour:
- One clock, clk. reset is synchronous and active-high; it is sampled only on the rising edge of clk.
- Reset values:
  - a_readdatavalid = 0, b_readdatavalid = 0, b_collision = 0.
  - a_readdata and b_readdata = 0.
  - Pipeline valid bits are cleared.
  - Memory contents are NOT cleared.
- reset has priority over clken.
- clken=0:
  - No memory write, no pipeline advance.
  - Outputs hold their values, including a valid bit that is already high.
- Request qualification: read request = chipselect & read & clken. Write = b_chipselect & b_write & clken.
- Port A is read-only. Port B may assert read and write together; that is treated as a write only, and readdatavalid is not raised.
- Byte-enabled write: lane i (bits 8i+7:8i) is updated only when b_byteenable[i]=1. b_byteenable = 0 is a no-op.
- Read latency:
  - Read accepted at edge N gives readdata and readdatavalid=1 after edge N+READ_LAT (with clken high on each edge).
  - readdatavalid is high for exactly one enabled cycle per accepted read.
  - Back-to-back reads sustain 1 read per cycle per port. No waitrequest is provided; the slave never stalls.
- Same-port forwarding: a read on port B in the cycle immediately after a port B write to the same address returns the new data, with the written lanes merged.
- Cross-port collision, port A read and port B write to the same address in the same cycle:
  - Port A returns the OLD data.
  - b_collision sets and stays set until reset.
  - The write always completes.
- Address wrap: addresses are word addresses taken modulo depth; no out-of-range detection.
- Reset mid-operation: in-flight reads are discarded, so no readdatavalid appears after reset. A write accepted on the reset edge still updates memory.

Decomposition:
- Shared package onchip_mem_pkg:
  - legal READ_LAT values
  - BE_W derivation helper function
  - default ADDR_W/DATA_W constants
- Sub-module onchip_mem_bank:
  - one true-dual-port RAM (read port A; read/write port B), with byte enables and INIT_FILE.
  - Instantiated once.
- Top level owns the valid pipelines, the forwarding/collision compare and the optional output register.

Test Plan:
- Reset, then port A read of addr 0x000 with INIT_FILE word 0x3C1D0000:
  - a_readdatavalid pulses 1 cycle after the request for READ_LAT=1, 2 cycles for READ_LAT=2.
  - a_readdata = 0x3C1D0000.
- Port B write 0xDEADBEEF to 0x7FF with byteenable 4'b0101 over 0x11223344, then read:
  - b_readdata = 0x11AD33EF.
  - A write to address 0x800 (wrapped) lands at 0x000.
- Port B write of 0xCAFEF00D to 0x010, read of 0x010 in the next cycle → returns 0xCAFEF00D (forwarding).
- Same-cycle port A read and port B write 0x12345678 to 0x020 (old value 0x0):
  - a_readdata = 0x00000000, b_collision = 1 and sticky.
  - A later port A read returns 0x12345678.
- 8 back-to-back port A reads, clken held low for 3 cycles mid-burst:
  - 8 valid pulses, in order, no duplicates, outputs frozen while clken = 0.
- Port A read issued, reset asserted on the next edge:
  - no readdatavalid afterwards; b_collision = 0; memory contents preserved.
